// File: rtl/wam_mgen.sv
// Whac-A-Mole mole generator: LFSR-driven spawning, per-hole lifetime counters,
// and whack resolution with registered hit/miss/wrong reporting.
module wam_mgen #(
   parameter int unsigned NHOLE = 8,
   parameter int unsigned HBITS = 3,
   parameter logic [7:0]  SEED  = 8'hA5
) (
   input  logic             clk_19,
   input  logic             rst_n,
   input  logic             run,
   input  logic             tick,
   input  logic [3:0]       age,
   input  logic [7:0]       rto,
   input  logic [NHOLE-1:0] whack,
   output logic [NHOLE-1:0] mole,
   output logic [HBITS:0]   hit_n,
   output logic [HBITS:0]   miss_n,
   output logic             wrong
);

   logic [7:0]                 r_lfsr;
   logic [NHOLE-1:0]           r_mole;
   logic [NHOLE-1:0][3:0]      r_life;
   logic [HBITS:0]             r_hit_n;
   logic [HBITS:0]             r_miss_n;
   logic                       r_wrong;

   logic [7:0]                 w_lfsr_d;
   logic [HBITS-1:0]           w_cand;
   logic [6:0]                 w_rnd;
   logic                       w_spawn;
   logic [3:0]                 w_age_eff;
   logic [NHOLE-1:0]           w_mole_d;
   logic [NHOLE-1:0][3:0]      w_life_d;
   logic [NHOLE-1:0]           w_hit;
   logic [NHOLE-1:0]           w_expire;
   logic                       w_wrong;

   function automatic logic [HBITS:0] popcnt(input logic [NHOLE-1:0] v);
      logic [HBITS:0] n;
      n = '0;
      for (int i = 0; i < int'(NHOLE); i++) begin
         n = n + {{HBITS{1'b0}}, v[i]};
      end
      return n;
   endfunction

   assign w_lfsr_d  = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
   assign w_cand    = r_lfsr[HBITS-1:0];
   assign w_rnd     = r_lfsr[7:1];
   assign w_age_eff = (age == 4'd0) ? 4'd1 : age;
   // Spawning only ever targets an empty hole, so it never collides with ageing or a hit.
   assign w_spawn   = run & tick & ({1'b0, w_rnd} < rto) & ~r_mole[w_cand];
   assign w_wrong   = run & (|(whack & ~r_mole));

   always_comb begin
      w_mole_d = r_mole;
      w_life_d = r_life;
      w_hit    = '0;
      w_expire = '0;
      if (!run) begin
         w_mole_d = '0;
         w_life_d = '0;
      end else begin
         for (int i = 0; i < int'(NHOLE); i++) begin
            if (whack[i] && r_mole[i]) begin
               w_hit[i]    = 1'b1;
               w_mole_d[i] = 1'b0;
               w_life_d[i] = 4'd0;
            end else if (tick && r_mole[i]) begin
               if (r_life[i] <= 4'd1) begin
                  w_expire[i] = 1'b1;
                  w_mole_d[i] = 1'b0;
                  w_life_d[i] = 4'd0;
               end else begin
                  w_life_d[i] = r_life[i] - 4'd1;
               end
            end else if (w_spawn && (w_cand == HBITS'(i))) begin
               w_mole_d[i] = 1'b1;
               w_life_d[i] = w_age_eff;
            end
         end
      end
   end

   always_ff @(posedge clk_19 or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr   <= SEED;
         r_mole   <= '0;
         r_life   <= '0;
         r_hit_n  <= '0;
         r_miss_n <= '0;
         r_wrong  <= 1'b0;
      end else begin
         r_lfsr   <= w_lfsr_d;
         r_mole   <= w_mole_d;
         r_life   <= w_life_d;
         r_hit_n  <= popcnt(w_hit);
         r_miss_n <= popcnt(w_expire);
         r_wrong  <= w_wrong;
      end
   end

   assign mole   = r_mole;
   assign hit_n  = r_hit_n;
   assign miss_n = r_miss_n;
   assign wrong  = r_wrong;

endmodule

// File: tb/tb_wam_mgen.sv
// Bench for wam_mgen: integer lifetime model checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_wam_mgen;

   localparam int NHOLE = 8;

   logic             clk_19 = 1'b0;
   logic             rst_n  = 1'b1;
   logic             run    = 1'b0;
   logic             tick   = 1'b0;
   logic [3:0]       age    = 4'd0;
   logic [7:0]       rto    = 8'd0;
   logic [NHOLE-1:0] whack  = '0;
   logic [NHOLE-1:0] mole;
   logic [3:0]       hit_n;
   logic [3:0]       miss_n;
   logic             wrong;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: remaining lifetime per hole, 0 meaning empty.
   int               m_life [NHOLE];
   int               m_lfsr;
   logic [NHOLE-1:0] exp_mole  = '0;
   int               exp_hit   = 0;
   int               exp_miss  = 0;
   int               exp_wrong = 0;

   wam_mgen #(.NHOLE(8), .HBITS(3), .SEED(8'hA5)) dut (
      .clk_19 (clk_19),
      .rst_n  (rst_n),
      .run    (run),
      .tick   (tick),
      .age    (age),
      .rto    (rto),
      .whack  (whack),
      .mole   (mole),
      .hit_n  (hit_n),
      .miss_n (miss_n),
      .wrong  (wrong)
   );

   always #5 clk_19 = ~clk_19;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_lfsr = 8'hA5;
      for (int i = 0; i < NHOLE; i++) m_life[i] = 0;
      exp_mole  = '0;
      exp_hit   = 0;
      exp_miss  = 0;
      exp_wrong = 0;
   endtask

   task automatic model_step();
      int nl [NHOLE];
      int h, ms, wr, c, r, fb;
      h = 0; ms = 0; wr = 0;
      if (!rst_n) return;
      c = m_lfsr % NHOLE;
      r = m_lfsr / 2;
      for (int i = 0; i < NHOLE; i++) nl[i] = 0;
      if (run) begin
         for (int i = 0; i < NHOLE; i++) begin
            nl[i] = m_life[i];
            if (whack[i]) begin
               if (m_life[i] > 0) begin
                  h++;
                  nl[i] = 0;
               end else begin
                  wr = 1;
               end
            end else if (tick && m_life[i] > 0) begin
               if (m_life[i] == 1) begin
                  ms++;
                  nl[i] = 0;
               end else begin
                  nl[i] = m_life[i] - 1;
               end
            end
         end
         if (tick && r < int'(rto) && m_life[c] == 0) nl[c] = (age == 0) ? 1 : int'(age);
      end
      for (int i = 0; i < NHOLE; i++) begin
         m_life[i]   = nl[i];
         exp_mole[i] = (nl[i] > 0);
      end
      fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
      m_lfsr    = ((m_lfsr << 1) & 8'hFE) | fb;
      exp_hit   = h;
      exp_miss  = ms;
      exp_wrong = wr;
   endtask

   always @(negedge clk_19) begin
      check("mole", int'(mole), int'(exp_mole));
      check("hit_n", int'(hit_n), exp_hit);
      check("miss_n", int'(miss_n), exp_miss);
      check("wrong", int'(wrong), exp_wrong);
   end

   task automatic step(input logic t, input logic [NHOLE-1:0] w);
      tick  = t;
      whack = w;
      @(posedge clk_19);
      model_step();
      @(negedge clk_19);
      tick  = 1'b0;
      whack = '0;
   endtask

   // Called at a falling edge; releases reset at a later falling edge.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      run   = 1'b0;
      model_reset();
      @(negedge clk_19);
      check("rst_mole", int'(mole), 0);
      check("rst_hit", int'(hit_n), 0);
      @(negedge clk_19);
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      #1 rst_n = 1'b0;
      @(negedge clk_19);
      @(negedge clk_19);
      check("rst_miss", int'(miss_n), 0);
      check("rst_wrong", int'(wrong), 0);
      rst_n = 1'b1;

      // First tick spawns at hole 5 (r=82<87), then it ages out after three more ticks.
      run = 1'b1; rto = 8'd87; age = 4'd3;
      step(1'b1, '0);
      check("spawn_h5", int'(mole), 8'h20);
      rto = 8'd0;
      step(1'b1, '0);
      step(1'b0, '0);
      step(1'b1, '0);
      check("alive_h5", int'(mole), 8'h20);
      step(1'b1, '0);
      check("expire_mole", int'(mole), 0);
      check("expire_miss", int'(miss_n), 1);
      step(1'b0, '0);
      check("miss_pulse_end", int'(miss_n), 0);

      // Spawn threshold below r, then rto=0 for 200 ticks.
      do_reset();
      run = 1'b1; rto = 8'd76; age = 4'd3;
      step(1'b1, '0);
      check("no_spawn_76", int'(mole), 0);
      rto = 8'd0;
      repeat (200) step(1'b1, '0);
      check("no_spawn_rto0", int'(mole), 0);

      // Whack lands on the expiring tick: hit wins.
      do_reset();
      run = 1'b1; rto = 8'd87; age = 4'd3;
      step(1'b1, '0);
      rto = 8'd0;
      step(1'b1, '0);
      step(1'b1, '0);
      step(1'b1, 8'h20);
      check("hitwin_hit", int'(hit_n), 1);
      check("hitwin_miss", int'(miss_n), 0);
      check("hitwin_mole", int'(mole), 0);
      step(1'b0, '0);
      check("hit_pulse_end", int'(hit_n), 0);

      // Whack on empty hole 5 while spawning into it; then whack empty hole 0.
      do_reset();
      run = 1'b1; rto = 8'd87; age = 4'd3;
      step(1'b1, 8'h20);
      check("ws_wrong", int'(wrong), 1);
      check("ws_mole", int'(mole), 8'h20);
      step(1'b0, '0);
      check("wrong_end", int'(wrong), 0);
      step(1'b0, 8'h01);
      check("wrong_h0", int'(wrong), 1);
      check("wrong_h0_hit", int'(hit_n), 0);
      check("wrong_h0_mole", int'(mole), 8'h20);

      // age=0 behaves as a one-tick lifetime.
      do_reset();
      run = 1'b1; rto = 8'd87; age = 4'd0;
      step(1'b1, '0);
      check("age0_spawn", int'(mole), 8'h20);
      rto = 8'd0;
      step(1'b1, '0);
      check("age0_miss", int'(miss_n), 1);
      check("age0_mole", int'(mole), 0);

      // Saturated spawning until holes 0 and 5 are both live, then a double hit.
      do_reset();
      run = 1'b1; rto = 8'd255; age = 4'd15;
      for (int k = 0; k < 300 && !(m_life[0] > 0 && m_life[5] > 0); k++) step(1'b1, '0);
      check("fill_h0_h5", int'(mole[0] & mole[5]), 1);
      step(1'b0, 8'h21);
      check("double_hit", int'(hit_n), 2);
      check("double_mole", int'(mole & 8'h21), 0);
      repeat (4) step(1'b1, '0);

      // Dropping run clears everything silently; tick and whack ignored.
      run = 1'b0;
      step(1'b1, 8'hFF);
      check("stop_mole", int'(mole), 0);
      check("stop_miss", int'(miss_n), 0);
      check("stop_hit", int'(hit_n), 0);
      check("stop_wrong", int'(wrong), 0);

      // Asynchronous reset mid-cycle, then the LFSR restarts from A5.
      run = 1'b1;
      repeat (6) step(1'b1, '0);
      @(posedge clk_19);
      model_step();
      #3;
      rst_n = 1'b0;
      #1;
      check("async_mole", int'(mole), 0);
      check("async_hit", int'(hit_n), 0);
      check("async_miss", int'(miss_n), 0);
      check("async_wrong", int'(wrong), 0);
      model_reset();
      @(negedge clk_19);
      @(negedge clk_19);
      rst_n = 1'b1;
      rto = 8'd87; age = 4'd3;
      step(1'b1, '0);
      check("reseed_spawn", int'(mole), 8'h20);
      step(1'b0, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
